// File: rtl/fifo_reader.sv
// Pops words from a show-ahead FIFO into a single registered output slot with valid/ready handshake.
// Optional out_parity register enabled by defining FIFO_READER_PARITY_EN.
module fifo_reader #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_pop,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic [CNT_W-1:0]  words_read
`ifdef FIFO_READER_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t state, state_nxt;
    logic   load;
    logic   xfer;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The slot refills in the same cycle it drains, giving one word per cycle.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    load      = 1'b1;
                    state_nxt = VALID;
                end
            end
            VALID: begin
                if (out_ready) begin
                    if (enable && !fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign fifo_pop  = load & reset;
    assign out_valid = (state == VALID);
    assign busy      = out_valid;
    assign xfer      = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data <= '0;
        end else if (load) begin
            out_data <= fifo_data;
        end
    end

    // Clear wins over a concurrent transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            words_read <= '0;
        end else if (clear) begin
            words_read <= '0;
        end else if (xfer) begin
            words_read <= words_read + CNT_W'(1);
        end
    end

`ifdef FIFO_READER_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_parity <= 1'b0;
        end else if (load) begin
            out_parity <= ^fifo_data;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader; a second narrow-counter instance exercises words_read wrap.
// Parity checks are included when FIFO_READER_PARITY_EN is defined.
module tb_fifo_reader;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        clear;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic        out_ready;

    logic        fifo_pop;
    logic        out_valid;
    logic [31:0] out_data;
    logic        busy;
    logic [15:0] words_read;

    logic        s_fifo_pop;
    logic        s_out_valid;
    logic [31:0] s_out_data;
    logic        s_busy;
    logic [3:0]  s_words_read;

`ifdef FIFO_READER_PARITY_EN
    logic        out_parity;
    logic        s_out_parity;
`endif

    int n_chk = 0;
    int n_err = 0;

    fifo_reader #(.DATA_W(32), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .clear      (clear),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .busy       (busy),
        .words_read (words_read)
`ifdef FIFO_READER_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    fifo_reader #(.DATA_W(32), .CNT_W(4)) dut_small (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .clear      (clear),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_pop   (s_fifo_pop),
        .out_ready  (out_ready),
        .out_valid  (s_out_valid),
        .out_data   (s_out_data),
        .busy       (s_busy),
        .words_read (s_words_read)
`ifdef FIFO_READER_PARITY_EN
        ,
        .out_parity (s_out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        enable     = 1'b1;
        clear      = 1'b0;
        fifo_empty = 1'b0;
        fifo_data  = 32'h0000_00A5;
        out_ready  = 1'b1;
        #1;
        chk("rst_pop",   {31'd0, fifo_pop},  32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy",  {31'd0, busy},      32'd0);
        chk("rst_data",  out_data,           32'd0);
        chk("rst_cnt",   {16'd0, words_read}, 32'd0);
        cyc();
        cyc();
        chk("rst_hold_valid", {31'd0, out_valid}, 32'd0);

        // First word straight after reset release
        #2;
        reset = 1'b1;
        #1;
        chk("first_pop", {31'd0, fifo_pop}, 32'd1);
        cyc();
        fifo_empty = 1'b1;
        #1;
        chk("first_valid", {31'd0, out_valid}, 32'd1);
        chk("first_data",  out_data,           32'h0000_00A5);
        chk("first_busy",  {31'd0, busy},      32'd1);
        chk("first_nopop", {31'd0, fifo_pop},  32'd0);
`ifdef FIFO_READER_PARITY_EN
        chk("first_par", {31'd0, out_parity}, 32'd0);
`endif
        cyc();
        chk("first_idle", {31'd0, out_valid}, 32'd0);
        chk("first_cnt",  {16'd0, words_read}, 32'd1);

        // Back-to-back stream of four words
        clear      = 1'b1;
        fifo_empty = 1'b0;
        fifo_data  = 32'h11;
        #1;
        chk("b2b_pop0", {31'd0, fifo_pop}, 32'd1);
        cyc();
        clear = 1'b0;
        chk("b2b_clr", {16'd0, words_read}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            fifo_data = 32'h22 + 32'(i) * 32'h11;
            #1;
            chk("b2b_data", out_data, 32'h11 + 32'(i) * 32'h11);
            chk("b2b_pop",  {31'd0, fifo_pop}, 32'd1);
            cyc();
        end
        fifo_empty = 1'b1;
        #1;
        chk("b2b_data3", out_data, 32'h44);
        chk("b2b_pop3",  {31'd0, fifo_pop}, 32'd0);
        cyc();
        chk("b2b_idle", {31'd0, out_valid}, 32'd0);
        chk("b2b_cnt",  {16'd0, words_read}, 32'd4);

        // Stall with held word; enable toggled to show the word is kept
        fifo_empty = 1'b0;
        fifo_data  = 32'h22;
        out_ready  = 1'b0;
        #1;
        chk("stall_pop0", {31'd0, fifo_pop}, 32'd1);
        cyc();
        fifo_data = 32'h55;
        for (int i = 0; i < 5; i++) begin
            enable = (i % 2 == 0);
            #1;
            chk("stall_pop",   {31'd0, fifo_pop},  32'd0);
            chk("stall_data",  out_data,           32'h22);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            cyc();
        end
        enable    = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("stall_release_pop", {31'd0, fifo_pop}, 32'd1);
        cyc();
        fifo_empty = 1'b1;
        #1;
        chk("stall_next_data", out_data, 32'h55);
        cyc();
        chk("stall_cnt", {16'd0, words_read}, 32'd6);

        // Empty FIFO: nothing happens
        for (int i = 0; i < 10; i++) begin
            chk("empty_pop",   {31'd0, fifo_pop},  32'd0);
            chk("empty_valid", {31'd0, out_valid}, 32'd0);
            chk("empty_busy",  {31'd0, busy},      32'd0);
            cyc();
        end

        // Stream to push the narrow counter through its wrap point
        fifo_empty = 1'b0;
        fifo_data  = 32'h66;
        for (int i = 0; i < 10; i++) cyc();
        chk("wrap_pre_cnt",   {16'd0, words_read},  32'd15);
        chk("wrap_pre_small", {28'd0, s_words_read}, 32'hF);
        cyc();
        chk("wrap_cnt",   {16'd0, words_read},  32'd16);
        chk("wrap_small", {28'd0, s_words_read}, 32'h0);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clr_xfer_cnt",   {16'd0, words_read},  32'd0);
        chk("clr_xfer_small", {28'd0, s_words_read}, 32'd0);
        fifo_empty = 1'b1;
        cyc();
        chk("post_clr_cnt",   {16'd0, words_read}, 32'd1);
        chk("post_clr_valid", {31'd0, out_valid},  32'd0);
        chk("small_valid",    {31'd0, s_out_valid}, {31'd0, out_valid});

        // Async reset while a word is held
        fifo_empty = 1'b0;
        fifo_data  = 32'h0000_0007;
        out_ready  = 1'b0;
        cyc();
        fifo_empty = 1'b1;
        #1;
        chk("ar_pre_valid", {31'd0, out_valid}, 32'd1);
        chk("ar_pre_data",  out_data,           32'h7);
`ifdef FIFO_READER_PARITY_EN
        chk("ar_pre_par", {31'd0, out_parity}, 32'd1);
`endif
        #1;
        fifo_empty = 1'b0;
        out_ready  = 1'b1;
        reset      = 1'b0;
        #1;
        chk("ar_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_data",  out_data,           32'd0);
        chk("ar_busy",  {31'd0, busy},      32'd0);
        chk("ar_pop",   {31'd0, fifo_pop},  32'd0);
        chk("ar_cnt",   {16'd0, words_read}, 32'd0);
`ifdef FIFO_READER_PARITY_EN
        chk("ar_par", {31'd0, out_parity}, 32'd0);
`endif
        cyc();
        chk("ar_hold_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_hold_pop",   {31'd0, fifo_pop},  32'd0);
        chk("ar_small_data", s_out_data,         32'd0);
        chk("ar_small_busy", {31'd0, s_busy},    32'd0);
        fifo_empty = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("ar_rel_pop", {31'd0, fifo_pop}, 32'd0);
        chk("ar_rel_small_pop", {31'd0, s_fifo_pop}, 32'd0);
        cyc();
        chk("ar_rel_valid", {31'd0, out_valid}, 32'd0);
`ifdef FIFO_READER_PARITY_EN
        chk("ar_small_par", {31'd0, s_out_parity}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
